scsi_byte_packer: RTL and testbench
===================================

Name: scsi_byte_packer

Overview:
- Byte-to-longword datapath stage between the 8-bit WD33C93A peripheral port and the 32-bit DMA FIFO.
- Pack mode (SCSI->memory): assembles four peripheral bytes into one big-endian longword for the FIFO.
- Unpack mode (memory->SCSI): splits a FIFO longword into four bytes, most-significant first.
- Exports the byte pointer (BO, BOEQ0, BOEQ3) consumed by the SCSI and CPU state machines.

Parameters:
- MSB_FIRST, 1: 1 = first byte in DATA[31:24] (68k order); 0 = first byte in DATA[7:0].
- FLUSH_ZERO, 1: 1 = unused lanes of a partial longword driven 0; 0 = previous contents held.

Ports:
- CLK  in  1  CPU clock (SCLK); all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENA  in  1  DMA enabled; low = synchronous abort.
- DMADIR  in  1  1 = pack (SCSI->memory), 0 = unpack; sampled only when leaving IDLE.
- FLUSH  in  1  single-cycle request to terminate the current longword.
- FLUSH_DONE  out  1  one-cycle pulse when a flush completes.
- B_IN  in  8  byte from peripheral port.
- B_IN_VLD  in  1  B_IN valid.
- B_IN_RDY  out  1  packer can accept B_IN.
- B_OUT  out  8  byte to peripheral port.
- B_OUT_VLD  out  1  B_OUT valid.
- B_OUT_RDY  in  1  peripheral side accepts B_OUT.
- LW_IN  in  32  longword from FIFO.
- LW_IN_VLD  in  1  LW_IN valid.
- LW_IN_RDY  out  1  unpacker can load LW_IN.
- LW_OUT  out  32  longword to FIFO.
- LW_OUT_BE  out  4  byte enables for LW_OUT; bit 3 = DATA[31:24].
- LW_OUT_VLD  out  1  LW_OUT valid.
- LW_OUT_RDY  in  1  FIFO accepts LW_OUT.
- BO  out  2  current byte offset (lane index, 0 = first byte).
- BOEQ0  out  1  BO==0.
- BOEQ3  out  1  BO==3.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE; BO=0; BOEQ0=1; BOEQ3=0; hold register 0; all VLD/RDY outputs 0; FLUSH_DONE=0; BUSY=0; LW_OUT_BE=0.
- Handshakes: a transfer occurs on an edge where VLD&RDY are both high. All outputs are registered; no combinational VLD->RDY paths.
- States: IDLE, PACK, PACK_OUT, UNPACK_LD, UNPACK, FLUSH_WAIT.
- IDLE: on ENA=1, go to PACK if DMADIR=1, else UNPACK_LD.
- PACK:
  - B_IN_RDY=1. On each byte transfer, the byte is written to lane BO and BO increments mod 4.
  - When the transfer happens at BO==3, the next state is PACK_OUT with BE=1111.
- PACK_OUT:
  - B_IN_RDY=0, LW_OUT_VLD=1.
  - On the LW transfer, BO=0 and the state returns to PACK; B_IN_RDY=1 on the following cycle.
  - Latency: 4th byte accepted at edge n -> LW_OUT_VLD high from edge n.
- FLUSH in pack mode:
  - If BO==0 and no word is held, FLUSH_DONE pulses the next cycle.
  - Otherwise go to PACK_OUT with BE covering lanes 0..BO-1 (BO==0 after a full word: BE=1111). Unused lanes follow FLUSH_ZERO.
  - Enter FLUSH_WAIT on the transfer; FLUSH_DONE pulses one cycle later; return to PACK.
  - FLUSH arriving in the same cycle as a byte transfer: the byte is stored first, then the flush applies.
- UNPACK_LD:
  - LW_IN_RDY=1. On transfer, latch LW_IN, set BO=0, go to UNPACK.
- UNPACK:
  - B_OUT_VLD=1, B_OUT = lane BO. Each transfer increments BO.
  - The transfer at BO==3 returns to UNPACK_LD (BO wraps to 0).
  - FLUSH in UNPACK discards the remaining bytes, sets BO=0, pulses FLUSH_DONE, then goes to UNPACK_LD.
- ENA low in any state: next edge -> IDLE, BO=0, all VLD/RDY low, held data discarded, no FLUSH_DONE.
- DMADIR changes while BUSY are ignored.
- RST mid-transfer returns to reset values immediately (asynchronous).
- BOEQ0 and BOEQ3 are registered alongside BO, so they are never stale.

Optional Feature:
- Macro: SCSI_PACK_BYTECNT_EN.
- Defined: adds output BYTE_CNT [23:0].
  - Counts byte-side transfers in both modes.
  - Cleared on the IDLE->active transition and on RST.
  - Saturates at 24'hFFFFFF.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package resdmac_pkg holds:
  - the state enum localparams;
  - lane index constants;
  - the BO->partial-BE table (0:1111, 1:1000, 2:1100, 3:1110 for MSB_FIRST=1; mirrored for MSB_FIRST=0).
- One sub-module, pack_lane_sel: combinational lane steering (byte->lane write enable, lane->byte read mux) honouring MSB_FIRST.

Test Plan:
- Pack, MSB_FIRST=1: bytes 11,22,33,44 -> LW_OUT=32'h11223344, BE=1111. LW_OUT_RDY held low 3 cycles -> B_IN_RDY stays 0, LW_OUT stable.
- Pack partial flush: bytes AA,BB then FLUSH -> LW_OUT=32'hAABB0000, BE=1100; FLUSH_DONE one cycle after the transfer; BO=0.
- Unpack: LW_IN=32'hDEADBEEF -> B_OUT sequence DE,AD,BE,EF; BOEQ3 high during EF; LW_IN_RDY=1 the cycle after EF transfers.
- Unpack flush after 2 bytes (DE,AD) -> BO=0, FLUSH_DONE pulse, next LW_IN=32'h01020304 yields 01 first.
- Abort/reset: ENA low after 3 packed bytes -> IDLE next edge, no LW_OUT_VLD. RST asserted mid-UNPACK -> all outputs at reset values without a clock edge.
- With SCSI_PACK_BYTECNT_EN: 10 pack bytes plus flush -> BYTE_CNT=10; the next ENA rise clears it to 0.

Source files
------------

// File: rtl/resdmac_pkg.sv
// Shared types and constants for the SCSI byte packer: FSM states, lane
// indices and the byte-pointer to partial-byte-enable table.
package resdmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PACK,
    ST_PACK_OUT,
    ST_UNPACK_LD,
    ST_UNPACK,
    ST_FLUSH_WAIT
  } state_t;

  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;
  localparam logic [3:0] BE_FULL    = 4'b1111;

  // Lanes 0..bo-1 are valid; bo==0 means a complete word.
  function automatic logic [3:0] partial_be(input logic [1:0] bo, input bit msb_first);
    logic [3:0] be;
    case (bo)
      2'd0:    be = 4'b1111;
      2'd1:    be = 4'b1000;
      2'd2:    be = 4'b1100;
      default: be = 4'b1110;
    endcase
    return msb_first ? be : {be[0], be[1], be[2], be[3]};
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/scsi_byte_packer_lane_sel.sv
// Lane steering for the byte packer: maps a logical lane (0 = first byte) to
// a physical byte position of the 32-bit word, for writes and for reads.
module pack_lane_sel
  import resdmac_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [1:0]  wr_lane,
  output logic [3:0]  wr_en,
  input  logic [1:0]  rd_lane,
  input  logic [31:0] rd_word,
  output logic [7:0]  rd_byte
);

  logic [1:0] wr_pos;
  logic [1:0] rd_pos;

  // Physical position 0 is DATA[7:0]; 68k order puts lane 0 at DATA[31:24].
  assign wr_pos = MSB_FIRST ? (LANE_LAST - wr_lane) : wr_lane;
  assign rd_pos = MSB_FIRST ? (LANE_LAST - rd_lane) : rd_lane;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_en         = '0;
    wr_en[wr_pos] = 1'b1;
  end

  assign rd_byte = rd_word[{rd_pos, 3'b000} +: 8];

endmodule

// File: rtl/scsi_byte_packer.sv
// Byte <-> longword packer between the WD33C93A 8-bit port and the DMA FIFO.
// Optional SCSI_PACK_BYTECNT_EN adds a saturating BYTE_CNT output.
module scsi_byte_packer
  import resdmac_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENA,
  input  logic        DMADIR,
  input  logic        FLUSH,
  output logic        FLUSH_DONE,
  input  logic [7:0]  B_IN,
  input  logic        B_IN_VLD,
  output logic        B_IN_RDY,
  output logic [7:0]  B_OUT,
  output logic        B_OUT_VLD,
  input  logic        B_OUT_RDY,
  input  logic [31:0] LW_IN,
  input  logic        LW_IN_VLD,
  output logic        LW_IN_RDY,
  output logic [31:0] LW_OUT,
  output logic [3:0]  LW_OUT_BE,
  output logic        LW_OUT_VLD,
  input  logic        LW_OUT_RDY,
  output logic [1:0]  BO,
  output logic        BOEQ0,
  output logic        BOEQ3,
`ifdef SCSI_PACK_BYTECNT_EN
  output logic [23:0] BYTE_CNT,
`endif
  output logic        BUSY
);

  state_t      state_q, state_d;
  logic [1:0]  bo_d;
  logic [31:0] hold_q, hold_d, hold_wr;
  logic        flush_pend_q, flush_pend_d;
  logic        done_d;
  logic [3:0]  out_be_d;
  logic [31:0] lw_out_d;
  logic [3:0]  wr_en;
  logic [7:0]  rd_byte;

  logic b_xfer, bo_xfer, lw_in_xfer, lw_out_xfer;
  assign b_xfer      = B_IN_VLD & B_IN_RDY;
  assign bo_xfer     = B_OUT_VLD & B_OUT_RDY;
  assign lw_in_xfer  = LW_IN_VLD & LW_IN_RDY;
  assign lw_out_xfer = LW_OUT_VLD & LW_OUT_RDY;

  pack_lane_sel #(.MSB_FIRST(MSB_FIRST)) u_lane_sel (
    .wr_lane (BO),
    .wr_en   (wr_en),
    .rd_lane (bo_d),
    .rd_word (hold_d),
    .rd_byte (rd_byte)
  );

  always_comb begin
    hold_wr = hold_q;
    for (int i = 0; i < 4; i++)
      if (wr_en[i]) hold_wr[8*i +: 8] = B_IN;
  end

  // Next state plus byte pointer / hold register / pending-flush bookkeeping.
  always_comb begin
    state_d      = state_q;
    bo_d         = BO;
    hold_d       = hold_q;
    flush_pend_d = flush_pend_q;
    done_d       = 1'b0;
    out_be_d     = LW_OUT_BE;
    if (!ENA) begin
      state_d      = ST_IDLE;
      bo_d         = LANE_FIRST;
      hold_d       = '0;
      flush_pend_d = 1'b0;
      out_be_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = DMADIR ? ST_PACK : ST_UNPACK_LD;
          bo_d    = LANE_FIRST;
        end
        ST_PACK: begin
          if (b_xfer) begin
            hold_d = hold_wr;
            bo_d   = BO + 2'd1;
          end
          if (b_xfer && BOEQ3) begin
            state_d      = ST_PACK_OUT;
            out_be_d     = BE_FULL;
            flush_pend_d = FLUSH;
          end else if (FLUSH) begin
            // The byte of this cycle (if any) is already in bo_d.
            if (bo_d == LANE_FIRST) begin
              done_d = 1'b1;
            end else begin
              state_d      = ST_PACK_OUT;
              out_be_d     = partial_be(bo_d, MSB_FIRST);
              flush_pend_d = 1'b1;
            end
          end
        end
        ST_PACK_OUT: begin
          if (lw_out_xfer) begin
            state_d      = (flush_pend_q || FLUSH) ? ST_FLUSH_WAIT : ST_PACK;
            bo_d         = LANE_FIRST;
            flush_pend_d = 1'b0;
            out_be_d     = '0;
          end else if (FLUSH) begin
            flush_pend_d = 1'b1;
          end
        end
        ST_FLUSH_WAIT: begin
          state_d = ST_PACK;
          done_d  = 1'b1;
        end
        ST_UNPACK_LD: begin
          if (lw_in_xfer) begin
            state_d = ST_UNPACK;
            hold_d  = LW_IN;
            bo_d    = LANE_FIRST;
          end else if (FLUSH) begin
            done_d = 1'b1;
          end
        end
        ST_UNPACK: begin
          if (bo_xfer) begin
            bo_d = BO + 2'd1;
            if (BOEQ3) state_d = ST_UNPACK_LD;
          end
          if (FLUSH) begin
            state_d = ST_UNPACK_LD;
            bo_d    = LANE_FIRST;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the next cycle, all derived from the next state.
  logic b_in_rdy_d, b_out_vld_d, lw_in_rdy_d, lw_out_vld_d, busy_d;
  always_comb begin
    b_in_rdy_d   = (state_d == ST_PACK);
    b_out_vld_d  = (state_d == ST_UNPACK);
    lw_in_rdy_d  = (state_d == ST_UNPACK_LD);
    lw_out_vld_d = (state_d == ST_PACK_OUT);
    busy_d       = (state_d != ST_IDLE);
    lw_out_d     = LW_OUT;
    if (!ENA)
      lw_out_d = '0;
    else if (state_d == ST_PACK_OUT && state_q != ST_PACK_OUT)
      lw_out_d = FLUSH_ZERO ? (hold_d & be_mask(out_be_d)) : hold_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      BO           <= LANE_FIRST;
      BOEQ0        <= 1'b1;
      BOEQ3        <= 1'b0;
      hold_q       <= '0;
      flush_pend_q <= 1'b0;
      FLUSH_DONE   <= 1'b0;
      B_IN_RDY     <= 1'b0;
      B_OUT        <= '0;
      B_OUT_VLD    <= 1'b0;
      LW_IN_RDY    <= 1'b0;
      LW_OUT       <= '0;
      LW_OUT_BE    <= '0;
      LW_OUT_VLD   <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state_q      <= state_d;
      BO           <= bo_d;
      BOEQ0        <= (bo_d == LANE_FIRST);
      BOEQ3        <= (bo_d == LANE_LAST);
      hold_q       <= hold_d;
      flush_pend_q <= flush_pend_d;
      FLUSH_DONE   <= done_d;
      B_IN_RDY     <= b_in_rdy_d;
      B_OUT        <= rd_byte;
      B_OUT_VLD    <= b_out_vld_d;
      LW_IN_RDY    <= lw_in_rdy_d;
      LW_OUT       <= lw_out_d;
      LW_OUT_BE    <= out_be_d;
      LW_OUT_VLD   <= lw_out_vld_d;
      BUSY         <= busy_d;
    end
  end

`ifdef SCSI_PACK_BYTECNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      BYTE_CNT <= '0;
    else if (state_q == ST_IDLE && state_d != ST_IDLE)
      BYTE_CNT <= '0;
    else if ((b_xfer || bo_xfer) && BYTE_CNT != 24'hFFFFFF)
      BYTE_CNT <= BYTE_CNT + 24'd1;
  end
`endif

endmodule

// File: tb/tb_scsi_byte_packer.sv
// Self-checking bench for scsi_byte_packer (default MSB_FIRST=1, FLUSH_ZERO=1);
// BYTE_CNT checks are built when SCSI_PACK_BYTECNT_EN is defined.
module tb_scsi_byte_packer;

  logic        CLK = 1'b0;
  logic        RST, ENA, DMADIR, FLUSH, FLUSH_DONE;
  logic [7:0]  B_IN, B_OUT;
  logic        B_IN_VLD, B_IN_RDY, B_OUT_VLD, B_OUT_RDY;
  logic [31:0] LW_IN, LW_OUT;
  logic        LW_IN_VLD, LW_IN_RDY, LW_OUT_VLD, LW_OUT_RDY;
  logic [3:0]  LW_OUT_BE;
  logic [1:0]  BO;
  logic        BOEQ0, BOEQ3, BUSY;
`ifdef SCSI_PACK_BYTECNT_EN
  logic [23:0] BYTE_CNT;
`endif

  scsi_byte_packer dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .DMADIR(DMADIR), .FLUSH(FLUSH),
    .FLUSH_DONE(FLUSH_DONE),
    .B_IN(B_IN), .B_IN_VLD(B_IN_VLD), .B_IN_RDY(B_IN_RDY),
    .B_OUT(B_OUT), .B_OUT_VLD(B_OUT_VLD), .B_OUT_RDY(B_OUT_RDY),
    .LW_IN(LW_IN), .LW_IN_VLD(LW_IN_VLD), .LW_IN_RDY(LW_IN_RDY),
    .LW_OUT(LW_OUT), .LW_OUT_BE(LW_OUT_BE), .LW_OUT_VLD(LW_OUT_VLD),
    .LW_OUT_RDY(LW_OUT_RDY),
    .BO(BO), .BOEQ0(BOEQ0), .BOEQ3(BOEQ3),
`ifdef SCSI_PACK_BYTECNT_EN
    .BYTE_CNT(BYTE_CNT),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    FLUSH = 1'b0; B_IN_VLD = 1'b0; B_OUT_RDY = 1'b0;
    LW_IN_VLD = 1'b0; LW_OUT_RDY = 1'b0;
  endtask

  task automatic enter(input logic dir);
    clear_inputs();
    ENA = 1'b0;
    tick();
    DMADIR = dir;
    ENA = 1'b1;
    tick();
  endtask

  typedef struct {
    int          nbytes;
    logic [31:0] din;        // bytes in order of arrival, first in [31:24]
    bit          flush_last; // FLUSH together with the last byte
    bit          flush_sep;  // FLUSH one cycle after the last byte
    int          stall;      // cycles LW_OUT_RDY is held low
    logic [31:0] exp_lw;
    logic [3:0]  exp_be;     // 0 = no word expected
  } pack_vec_t;

  task automatic pack_run(input int idx, input pack_vec_t v);
    string tag;
    bit flushed;
    tag = $sformatf("pack%0d", idx);
    flushed = v.flush_last || v.flush_sep;
    check({tag, " rdy at start"}, 32'(B_IN_RDY), 32'd1);
    for (int i = 0; i < v.nbytes; i++) begin
      B_IN     = v.din[31-8*i -: 8];
      B_IN_VLD = 1'b1;
      FLUSH    = v.flush_last && (i == v.nbytes - 1);
      tick();
      check({tag, " bo"}, 32'(BO), 32'((i + 1) % 4));
      check({tag, " boeq3"}, 32'(BOEQ3), 32'(((i + 1) % 4) == 3));
    end
    B_IN_VLD = 1'b0;
    FLUSH    = 1'b0;
    if (v.flush_sep) begin
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
    end
    if (v.exp_be == 4'h0) begin
      check({tag, " empty flush done"}, 32'(FLUSH_DONE), 32'd1);
      check({tag, " empty flush no word"}, 32'(LW_OUT_VLD), 32'd0);
      tick();
      check({tag, " done is a pulse"}, 32'(FLUSH_DONE), 32'd0);
      check({tag, " rdy after empty flush"}, 32'(B_IN_RDY), 32'd1);
    end else begin
      check({tag, " lw vld"}, 32'(LW_OUT_VLD), 32'd1);
      check({tag, " lw data"}, LW_OUT, v.exp_lw);
      check({tag, " lw be"}, 32'(LW_OUT_BE), 32'(v.exp_be));
      check({tag, " b_in_rdy low"}, 32'(B_IN_RDY), 32'd0);
      for (int s = 0; s < v.stall; s++) begin
        tick();
        check({tag, " stall rdy"}, 32'(B_IN_RDY), 32'd0);
        check({tag, " stall data"}, LW_OUT, v.exp_lw);
        check({tag, " stall vld"}, 32'(LW_OUT_VLD), 32'd1);
      end
      LW_OUT_RDY = 1'b1;
      tick();
      LW_OUT_RDY = 1'b0;
      check({tag, " vld drop"}, 32'(LW_OUT_VLD), 32'd0);
      check({tag, " bo reset"}, 32'(BO), 32'd0);
      if (flushed) begin
        check({tag, " done early"}, 32'(FLUSH_DONE), 32'd0);
        check({tag, " rdy in wait"}, 32'(B_IN_RDY), 32'd0);
        tick();
        check({tag, " done"}, 32'(FLUSH_DONE), 32'd1);
        check({tag, " rdy after flush"}, 32'(B_IN_RDY), 32'd1);
        tick();
        check({tag, " done is a pulse"}, 32'(FLUSH_DONE), 32'd0);
      end else begin
        check({tag, " rdy after word"}, 32'(B_IN_RDY), 32'd1);
        check({tag, " no done"}, 32'(FLUSH_DONE), 32'd0);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " b_in_rdy"}, 32'(B_IN_RDY), 32'd0);
    check({tag, " b_out_vld"}, 32'(B_OUT_VLD), 32'd0);
    check({tag, " lw_in_rdy"}, 32'(LW_IN_RDY), 32'd0);
    check({tag, " lw_out_vld"}, 32'(LW_OUT_VLD), 32'd0);
    check({tag, " lw_out_be"}, 32'(LW_OUT_BE), 32'd0);
    check({tag, " flush_done"}, 32'(FLUSH_DONE), 32'd0);
    check({tag, " busy"}, 32'(BUSY), 32'd0);
    check({tag, " bo"}, 32'(BO), 32'd0);
    check({tag, " boeq0"}, 32'(BOEQ0), 32'd1);
    check({tag, " boeq3"}, 32'(BOEQ3), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pack_vec_t   vt[7];
    logic [7:0]  bq[$];
    logic [31:0] wq[$];
    logic [31:0] w, pad;
    logic [3:0]  be;
    int          n, sent;
    bit          got;

    RST = 1'b1; ENA = 1'b0; DMADIR = 1'b0; B_IN = '0; LW_IN = '0;
    clear_inputs();
    tick();
    tick();
    check_reset_values("reset");
    RST = 1'b0;
    tick();

    // ---------------- table-driven pack vectors ----------------
    vt[0] = '{4, 32'h11223344, 1'b0, 1'b0, 3, 32'h11223344, 4'hF};
    vt[1] = '{2, 32'hAABB0000, 1'b0, 1'b1, 0, 32'hAABB0000, 4'hC};
    vt[2] = '{1, 32'h5A000000, 1'b0, 1'b1, 0, 32'h5A000000, 4'h8};
    vt[3] = '{3, 32'h01020300, 1'b0, 1'b1, 1, 32'h01020300, 4'hE};
    vt[4] = '{0, 32'h00000000, 1'b0, 1'b1, 0, 32'h00000000, 4'h0};
    vt[5] = '{4, 32'hC0FFEE11, 1'b1, 1'b0, 0, 32'hC0FFEE11, 4'hF};
    vt[6] = '{2, 32'h12340000, 1'b1, 1'b0, 0, 32'h12340000, 4'hC};
    enter(1'b1);
    check("pack busy", 32'(BUSY), 32'd1);
    for (int i = 0; i < 7; i++) pack_run(i, vt[i]);

    // ---------------- unpack, full word ----------------
    enter(1'b0);
    check("unpack lw_in_rdy", 32'(LW_IN_RDY), 32'd1);
    w = 32'hDEADBEEF;
    LW_IN = w; LW_IN_VLD = 1'b1;
    tick();
    LW_IN_VLD = 1'b0;
    check("unpack lw_in_rdy drop", 32'(LW_IN_RDY), 32'd0);
    B_OUT_RDY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("unpack b_out_vld", 32'(B_OUT_VLD), 32'd1);
      check("unpack b_out", 32'(B_OUT), 32'(w[31-8*k -: 8]));
      check("unpack bo", 32'(BO), 32'(k));
      check("unpack boeq3", 32'(BOEQ3), 32'(k == 3));
      tick();
    end
    B_OUT_RDY = 1'b0;
    check("unpack reload rdy", 32'(LW_IN_RDY), 32'd1);
    check("unpack vld after word", 32'(B_OUT_VLD), 32'd0);

    // ---------------- unpack flush after two bytes ----------------
    LW_IN = w; LW_IN_VLD = 1'b1;
    tick();
    LW_IN_VLD = 1'b0;
    B_OUT_RDY = 1'b1;
    tick();
    tick();
    B_OUT_RDY = 1'b0;
    check("uflush bo before", 32'(BO), 32'd2);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("uflush bo", 32'(BO), 32'd0);
    check("uflush done", 32'(FLUSH_DONE), 32'd1);
    check("uflush lw_in_rdy", 32'(LW_IN_RDY), 32'd1);
    check("uflush b_out_vld", 32'(B_OUT_VLD), 32'd0);
    tick();
    check("uflush done pulse", 32'(FLUSH_DONE), 32'd0);
    LW_IN = 32'h01020304; LW_IN_VLD = 1'b1;
    tick();
    LW_IN_VLD = 1'b0;
    check("uflush next first byte", 32'(B_OUT), 32'h01);

    // ---------------- abort with ENA low ----------------
    enter(1'b1);
    B_IN_VLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      B_IN = 8'(8'h70 + i);
      tick();
    end
    B_IN_VLD = 1'b0;
    check("abort bo before", 32'(BO), 32'd3);
    ENA = 1'b0;
    tick();
    check("abort busy", 32'(BUSY), 32'd0);
    check("abort bo", 32'(BO), 32'd0);
    check("abort b_in_rdy", 32'(B_IN_RDY), 32'd0);
    check("abort lw_out_vld", 32'(LW_OUT_VLD), 32'd0);
    check("abort no done", 32'(FLUSH_DONE), 32'd0);
    tick();
    check("abort stays quiet", 32'(LW_OUT_VLD), 32'd0);

    // ---------------- asynchronous reset mid-unpack ----------------
    enter(1'b0);
    LW_IN = 32'hCAFEF00D; LW_IN_VLD = 1'b1;
    tick();
    LW_IN_VLD = 1'b0;
    B_OUT_RDY = 1'b1;
    tick();
    B_OUT_RDY = 1'b0;
    check("pre-reset b_out_vld", 32'(B_OUT_VLD), 32'd1);
    #2 RST = 1'b1;
    #1;
    check_reset_values("async reset");
    tick();
    RST = 1'b0;
    tick();

    // ---------------- random pack against model ----------------
    enter(1'b1);
    bq.delete(); wq.delete();
    for (int c = 0; c < 400; c++) begin
      B_IN_VLD   = 1'($urandom_range(0, 1));
      B_IN       = 8'($urandom);
      LW_OUT_RDY = 1'($urandom_range(0, 1));
      DMADIR     = 1'($urandom_range(0, 1));
      if (B_IN_VLD && B_IN_RDY) begin
        bq.push_back(B_IN);
        if (bq.size() == 4) begin
          wq.push_back({bq[0], bq[1], bq[2], bq[3]});
          bq.delete();
        end
      end
      if (LW_OUT_VLD && LW_OUT_RDY) begin
        check("rnd pack word expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) check("rnd pack word", LW_OUT, wq.pop_front());
        check("rnd pack be", 32'(LW_OUT_BE), 32'hF);
      end
      tick();
    end
    B_IN_VLD = 1'b0;
    LW_OUT_RDY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (LW_OUT_VLD) begin
        check("rnd pack drain expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) check("rnd pack drain word", LW_OUT, wq.pop_front());
      end
      tick();
    end
    LW_OUT_RDY = 1'b0;
    check("rnd pack words left", 32'(wq.size()), 32'd0);
    n = bq.size();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    if (n == 0) begin
      check("rnd pack empty flush", 32'(FLUSH_DONE), 32'd1);
    end else begin
      pad = '0;
      for (int i = 0; i < n; i++) pad[31-8*i -: 8] = bq[i];
      be = 4'((15 << (4 - n)) & 15);
      check("rnd pack tail vld", 32'(LW_OUT_VLD), 32'd1);
      check("rnd pack tail word", LW_OUT, pad);
      check("rnd pack tail be", 32'(LW_OUT_BE), 32'(be));
      LW_OUT_RDY = 1'b1;
      tick();
      LW_OUT_RDY = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (!got) begin
          tick();
          if (FLUSH_DONE) got = 1'b1;
        end
      end
      check("rnd pack tail done", 32'(got), 32'd1);
    end

    // ---------------- random unpack against model ----------------
    enter(1'b0);
    bq.delete();
    for (int c = 0; c < 400; c++) begin
      LW_IN_VLD = 1'($urandom_range(0, 1));
      LW_IN     = $urandom;
      B_OUT_RDY = 1'($urandom_range(0, 1));
      DMADIR    = 1'($urandom_range(0, 1));
      if (LW_IN_VLD && LW_IN_RDY)
        for (int k = 0; k < 4; k++) bq.push_back(LW_IN[31-8*k -: 8]);
      if (B_OUT_VLD && B_OUT_RDY) begin
        check("rnd unpack byte expected", 32'(bq.size() != 0), 32'd1);
        if (bq.size() != 0) check("rnd unpack byte", 32'(B_OUT), 32'(bq.pop_front()));
      end
      tick();
    end
    LW_IN_VLD = 1'b0;
    B_OUT_RDY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (B_OUT_VLD) begin
        check("rnd unpack drain expected", 32'(bq.size() != 0), 32'd1);
        if (bq.size() != 0) check("rnd unpack drain byte", 32'(B_OUT), 32'(bq.pop_front()));
      end
      tick();
    end
    B_OUT_RDY = 1'b0;
    check("rnd unpack bytes left", 32'(bq.size()), 32'd0);
    check("rnd unpack reload rdy", 32'(LW_IN_RDY), 32'd1);

`ifdef SCSI_PACK_BYTECNT_EN
    // ---------------- byte counter ----------------
    enter(1'b1);
    check("bytecnt cleared on entry", 32'(BYTE_CNT), 32'd0);
    sent = 0;
    LW_OUT_RDY = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (sent < 10) begin
        B_IN = 8'(sent + 1);
        B_IN_VLD = 1'b1;
        got = B_IN_RDY;
        tick();
        if (got) sent++;
      end
    end
    B_IN_VLD = 1'b0;
    check("bytecnt bytes sent", 32'(sent), 32'd10);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!got) begin
        tick();
        if (FLUSH_DONE) got = 1'b1;
      end
    end
    LW_OUT_RDY = 1'b0;
    check("bytecnt flush done", 32'(got), 32'd1);
    check("bytecnt value", 32'(BYTE_CNT), 32'd10);
    ENA = 1'b0;
    tick();
    check("bytecnt held in idle", 32'(BYTE_CNT), 32'd10);
    ENA = 1'b1;
    tick();
    check("bytecnt cleared on restart", 32'(BYTE_CNT), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
